// File: rtl/id_bypass_stage_if.sv
// Bundles the upstream, register-file, forwarding and downstream signals of id_bypass_stage.
// master is the surrounding pipeline; slave is the bypass stage itself.
interface id_bypass_stage_if #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int PW   = 64,
    parameter int NFWD = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PW-1:0]        in_payload;
    logic [AW-1:0]        in_raddr1;
    logic [AW-1:0]        in_raddr2;
    logic                 in_use1;
    logic                 in_use2;
    logic                 flush;

    logic [AW-1:0]        rf_raddr1;
    logic [AW-1:0]        rf_raddr2;
    logic [DW-1:0]        rf_rdata1;
    logic [DW-1:0]        rf_rdata2;

    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD-1:0]      fwd_ready;
    logic [NFWD*AW-1:0]   fwd_dest;
    logic [NFWD*DW-1:0]   fwd_data;

    logic                 out_valid;
    logic                 out_ready;
    logic [PW-1:0]        out_payload;
    logic [DW-1:0]        out_src1;
    logic [DW-1:0]        out_src2;
    logic [31:0]          stall_cnt;

    modport master (
        output in_valid, in_payload, in_raddr1, in_raddr2, in_use1, in_use2, flush,
        output rf_rdata1, rf_rdata2,
        output fwd_valid, fwd_we, fwd_ready, fwd_dest, fwd_data,
        output out_ready,
        input  in_ready, rf_raddr1, rf_raddr2,
        input  out_valid, out_payload, out_src1, out_src2, stall_cnt
    );

    modport slave (
        input  in_valid, in_payload, in_raddr1, in_raddr2, in_use1, in_use2, flush,
        input  rf_rdata1, rf_rdata2,
        input  fwd_valid, fwd_we, fwd_ready, fwd_dest, fwd_data,
        input  out_ready,
        output in_ready, rf_raddr1, rf_raddr2,
        output out_valid, out_payload, out_src1, out_src2, stall_cnt
    );
endinterface

// File: rtl/id_bypass_stage.sv
// Single-entry decode stage with operand bypass from NFWD forwarding channels (channel 0 youngest).
// Define ID_BYPASS_FWD_EN to forward ready channel data; otherwise any match stalls the entry.
module id_bypass_stage #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int PW   = 64,
    parameter int NFWD = 3
) (
    input logic              clk,
    input logic              resetn,
    id_bypass_stage_if.slave bus
);

    logic          valid_q,    valid_d;
    logic [PW-1:0] payload_q,  payload_d;
    logic [AW-1:0] raddr1_q,   raddr1_d;
    logic [AW-1:0] raddr2_q,   raddr2_d;
    logic          use1_q,     use1_d;
    logic          use2_q,     use2_d;
    logic [31:0]   stallCnt_q, stallCnt_d;

    logic [NFWD-1:0] match1;
    logic [NFWD-1:0] match2;
    logic            hit1;
    logic            hit2;
    logic            blocked;
    logic            hazard;
    logic            go;
    logic            inReady;
    logic            outValid;
    logic            capture;
    logic            fire;
    logic [DW-1:0]   src1;
    logic [DW-1:0]   src2;

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < NFWD; i++) begin
            match1[i] = bus.fwd_valid[i] && bus.fwd_we[i] && (bus.fwd_dest[i*AW +: AW] != '0)
                        && use1_q && (raddr1_q == bus.fwd_dest[i*AW +: AW]);
            match2[i] = bus.fwd_valid[i] && bus.fwd_we[i] && (bus.fwd_dest[i*AW +: AW] != '0)
                        && use2_q && (raddr2_q == bus.fwd_dest[i*AW +: AW]);
        end
        hit1 = |match1;
        hit2 = |match2;
    end

`ifdef ID_BYPASS_FWD_EN
    logic          rdy1;
    logic          rdy2;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;

    // Walk from oldest to youngest so the lowest-index match is the one left standing.
    always_comb begin
        rdy1  = 1'b0;
        rdy2  = 1'b0;
        data1 = '0;
        data2 = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (match1[i]) begin
                rdy1  = bus.fwd_ready[i];
                data1 = bus.fwd_data[i*DW +: DW];
            end
            if (match2[i]) begin
                rdy2  = bus.fwd_ready[i];
                data2 = bus.fwd_data[i*DW +: DW];
            end
        end
        blocked = (hit1 && !rdy1) || (hit2 && !rdy2);
        src1    = (hit1 && rdy1) ? data1 : bus.rf_rdata1;
        src2    = (hit2 && rdy2) ? data2 : bus.rf_rdata2;
    end
`else
    always_comb begin
        blocked = hit1 || hit2;
        src1    = bus.rf_rdata1;
        src2    = bus.rf_rdata2;
    end
`endif

    always_comb begin
        hazard   = valid_q && blocked;
        go       = !hazard;
        outValid = valid_q && go && !bus.flush;
        inReady  = !valid_q || (go && bus.out_ready);
        fire     = outValid && bus.out_ready;
        capture  = bus.in_valid && inReady && !bus.flush;
    end

    // Flush wins over everything; a capture replaces a departing entry in the same cycle.
    always_comb begin
        valid_d    = valid_q;
        payload_d  = payload_q;
        raddr1_d   = raddr1_q;
        raddr2_d   = raddr2_q;
        use1_d     = use1_q;
        use2_d     = use2_q;
        stallCnt_d = stallCnt_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d   = 1'b1;
            payload_d = bus.in_payload;
            raddr1_d  = bus.in_raddr1;
            raddr2_d  = bus.in_raddr2;
            use1_d    = bus.in_use1;
            use2_d    = bus.in_use2;
        end else if (fire) begin
            valid_d = 1'b0;
        end
        if (hazard && !bus.flush && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q    <= 1'b0;
            payload_q  <= '0;
            raddr1_q   <= '0;
            raddr2_q   <= '0;
            use1_q     <= 1'b0;
            use2_q     <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            payload_q  <= payload_d;
            raddr1_q   <= raddr1_d;
            raddr2_q   <= raddr2_d;
            use1_q     <= use1_d;
            use2_q     <= use2_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.out_valid   = outValid;
    assign bus.out_payload = payload_q;
    assign bus.out_src1    = src1;
    assign bus.out_src2    = src2;
    assign bus.rf_raddr1   = raddr1_q;
    assign bus.rf_raddr2   = raddr2_q;
    assign bus.stall_cnt   = stallCnt_q;

endmodule

// File: tb/tb_id_bypass_stage.sv
// Randomized and directed bench for id_bypass_stage against a cycle-level behavioural model.
// Honours ID_BYPASS_FWD_EN the same way the design does.
module tb_id_bypass_stage;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int PW   = 64;
    localparam int NFWD = 3;
`ifdef ID_BYPASS_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic clk;
    logic resetn;
    int   checks;
    int   fails;

    logic [DW-1:0] rfMem [32];

    id_bypass_stage_if #(.DW(DW), .AW(AW), .PW(PW), .NFWD(NFWD)) bus ();

    id_bypass_stage #(.DW(DW), .AW(AW), .PW(PW), .NFWD(NFWD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    assign bus.rf_rdata1 = rfMem[bus.rf_raddr1];
    assign bus.rf_rdata2 = rfMem[bus.rf_raddr2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the held instruction and the stall counter
    logic          mValid;
    logic [PW-1:0] mPayload;
    logic [AW-1:0] mA1, mA2;
    logic          mU1, mU2;
    logic [31:0]   mStall;
    logic          expOutValid, expInReady, expHazard;
    logic [DW-1:0] expSrc1, expSrc2;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int selCh(input logic [AW-1:0] a, input logic u);
        logic [AW-1:0] d;
        for (int i = 0; i < NFWD; i++) begin
            d = bus.fwd_dest[i*AW +: AW];
            if (u && bus.fwd_valid[i] && bus.fwd_we[i] && d != 0 && d == a) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mValid = 0; mPayload = '0; mA1 = '0; mA2 = '0; mU1 = 0; mU2 = 0; mStall = '0;
    endtask

    task automatic computeExpected();
        int  s1, s2;
        logic stuck;
        s1 = selCh(mA1, mU1);
        s2 = selCh(mA2, mU2);
        if (FWD_EN)
            stuck = (s1 >= 0 && !bus.fwd_ready[s1]) || (s2 >= 0 && !bus.fwd_ready[s2]);
        else
            stuck = (s1 >= 0) || (s2 >= 0);
        expHazard   = mValid && stuck;
        expOutValid = mValid && !expHazard && !bus.flush;
        expInReady  = !mValid || (!expHazard && bus.out_ready);
        expSrc1 = (FWD_EN && s1 >= 0 && bus.fwd_ready[s1]) ? bus.fwd_data[s1*DW +: DW] : rfMem[mA1];
        expSrc2 = (FWD_EN && s2 >= 0 && bus.fwd_ready[s2]) ? bus.fwd_data[s2*DW +: DW] : rfMem[mA2];
    endtask

    task automatic compareModel();
        computeExpected();
        checkOutput("out_valid", 64'(bus.out_valid), 64'(expOutValid));
        checkOutput("in_ready",  64'(bus.in_ready),  64'(expInReady));
        checkOutput("rf_raddr1", 64'(bus.rf_raddr1), 64'(mA1));
        checkOutput("rf_raddr2", 64'(bus.rf_raddr2), 64'(mA2));
        checkOutput("out_src1",  64'(bus.out_src1),  64'(expSrc1));
        checkOutput("out_src2",  64'(bus.out_src2),  64'(expSrc2));
        checkOutput("stall_cnt", 64'(bus.stall_cnt), 64'(mStall));
        if (mValid) checkOutput("out_payload", bus.out_payload, mPayload);
    endtask

    task automatic modelUpdate();
        logic cap, fire;
        computeExpected();
        fire = expOutValid && bus.out_ready;
        cap  = bus.in_valid && expInReady && !bus.flush;
        if (expHazard && !bus.flush && mStall != 32'hFFFF_FFFF) mStall = mStall + 1;
        if (bus.flush) mValid = 0;
        else if (cap) begin
            mValid = 1; mPayload = bus.in_payload;
            mA1 = bus.in_raddr1; mA2 = bus.in_raddr2; mU1 = bus.in_use1; mU2 = bus.in_use2;
        end else if (fire) mValid = 0;
    endtask

    task automatic applyStimulus(input logic inV, input logic [PW-1:0] pay, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2, input logic u1, input logic u2,
                                 input logic fl, input logic outR);
        bus.in_valid = inV; bus.in_payload = pay; bus.in_raddr1 = a1; bus.in_raddr2 = a2;
        bus.in_use1 = u1; bus.in_use2 = u2; bus.flush = fl; bus.out_ready = outR;
    endtask

    task automatic setFwd(input int ch, input logic v, input logic we, input logic rdy,
                          input logic [AW-1:0] dest, input logic [DW-1:0] data);
        bus.fwd_valid[ch] = v; bus.fwd_we[ch] = we; bus.fwd_ready[ch] = rdy;
        bus.fwd_dest[ch*AW +: AW] = dest; bus.fwd_data[ch*DW +: DW] = data;
    endtask

    task automatic clearFwd();
        for (int c = 0; c < NFWD; c++) setFwd(c, 0, 0, 0, '0, '0);
    endtask

    task automatic evalCycle();
        #1;
        compareModel();
    endtask

    task automatic advance();
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic drain();
        clearFwd();
        applyStimulus(0, '0, '0, '0, 0, 0, 0, 1);
        repeat (2) begin evalCycle(); advance(); end
    endtask

    task automatic loadEntry(input logic [PW-1:0] pay, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                             input logic u1, input logic u2);
        clearFwd();
        applyStimulus(1, pay, a1, a2, u1, u2, 0, 1);
        evalCycle(); advance();
        applyStimulus(0, '0, '0, '0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [31:0] stallBase;
        checks = 0;
        fails  = 0;
        for (int r = 0; r < 32; r++) rfMem[r] = $urandom;
        resetn = 1'b0;
        clearFwd();
        applyStimulus(0, '0, '0, '0, 0, 0, 0, 0);
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_in_ready",  64'(bus.in_ready),  64'd1);
        checkOutput("reset_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Two ready channels hit the same register: the lower index wins
        drain();
        loadEntry(64'h32, 5'd5, 5'd0, 1, 0);
        setFwd(1, 1, 1, 1, 5'd5, 32'h1234);
        setFwd(2, 1, 1, 1, 5'd5, 32'h9999);
        evalCycle();
`ifdef ID_BYPASS_FWD_EN
        checkOutput("r032_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("r032_out_src1",  64'(bus.out_src1),  64'h1234);
`else
        checkOutput("r032_out_valid", 64'(bus.out_valid), 64'd0);
`endif
        advance();

        // Youngest channel not ready for two cycles
        drain();
        loadEntry(64'h33, 5'd0, 5'd7, 0, 1);
        stallBase = mStall;
        setFwd(0, 1, 1, 0, 5'd7, 32'hABCD);
        for (int k = 0; k < 2; k++) begin
            evalCycle();
            checkOutput("r033_out_valid", 64'(bus.out_valid), 64'd0);
            checkOutput("r033_in_ready",  64'(bus.in_ready),  64'd0);
            advance();
        end
        setFwd(0, 1, 1, 1, 5'd7, 32'hABCD);
        evalCycle();
        checkOutput("r033_stall_delta", 64'(bus.stall_cnt), 64'(stallBase + 32'd2));
`ifdef ID_BYPASS_FWD_EN
        checkOutput("r033_out_valid_rel", 64'(bus.out_valid), 64'd1);
        checkOutput("r033_out_src2",      64'(bus.out_src2),  64'hABCD);
`endif
        advance();

        // Register zero never matches a forwarding channel
        drain();
        loadEntry(64'h34, 5'd0, 5'd0, 1, 0);
        setFwd(0, 1, 1, 0, 5'd0, 32'hDEAD);
        evalCycle();
        checkOutput("r034_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("r034_out_src1",  64'(bus.out_src1),  64'(rfMem[0]));
        advance();

        // Flush of a stalled entry while a new one is offered
        drain();
        loadEntry(64'h35, 5'd3, 5'd0, 1, 0);
        setFwd(0, 1, 1, 0, 5'd3, 32'h0);
        evalCycle();
        checkOutput("r035_stalled", 64'(bus.out_valid), 64'd0);
        advance();
        stallBase = mStall;
        applyStimulus(1, 64'h77, 5'd1, 5'd1, 1, 1, 1, 1);
        evalCycle();
        checkOutput("r035_flush_out_valid", 64'(bus.out_valid), 64'd0);
        advance();
        clearFwd();
        applyStimulus(0, '0, '0, '0, 0, 0, 0, 1);
        evalCycle();
        checkOutput("r035_after_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("r035_after_in_ready",  64'(bus.in_ready),  64'd1);
        checkOutput("r035_stall_held",      64'(bus.stall_cnt), 64'(stallBase));
        advance();

        // Back-to-back stream at one instruction per cycle
        drain();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 64'(32'h100 + k), 5'd1, 5'd2, 1, 1, 0, 1);
            evalCycle();
            if (k > 0) begin
                checkOutput("r036_out_valid", 64'(bus.out_valid),  64'd1);
                checkOutput("r036_payload",   bus.out_payload,     64'(32'h100 + k - 1));
            end
            advance();
        end
        applyStimulus(0, '0, '0, '0, 0, 0, 0, 1);
        evalCycle();
        checkOutput("r036_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("r036_payload",   bus.out_payload,    64'h103);
        advance();

        // A ready match still stalls until the channel goes away when forwarding is off
        drain();
        loadEntry(64'h37, 5'd3, 5'd0, 1, 0);
        setFwd(2, 1, 1, 1, 5'd3, 32'h5555);
        for (int k = 0; k < 2; k++) begin
            evalCycle();
`ifndef ID_BYPASS_FWD_EN
            checkOutput("r037_stall", 64'(bus.out_valid), 64'd0);
`endif
            advance();
        end
        setFwd(2, 0, 1, 1, 5'd3, 32'h5555);
        evalCycle();
`ifndef ID_BYPASS_FWD_EN
        checkOutput("r037_release",  64'(bus.out_valid), 64'd1);
        checkOutput("r037_out_src1", 64'(bus.out_src1),  64'(rfMem[3]));
`endif
        advance();

        // Random traffic on a small address space so matches are frequent
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NFWD; c++)
                setFwd(c, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       AW'($urandom_range(0, 3)), $urandom);
            applyStimulus($urandom_range(0, 9) < 7, {$urandom, $urandom},
                          AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            evalCycle();
            advance();
        end

        // Asynchronous reset in the middle of traffic, then immediate resumption
        applyStimulus(1, 64'h55, 5'd2, 5'd3, 1, 1, 0, 0);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("midreset_in_ready",  64'(bus.in_ready),  64'd1);
        checkOutput("midreset_stall_cnt", 64'(bus.stall_cnt), 64'd0);
        modelReset();
        @(negedge clk);
        resetn = 1'b1;
        clearFwd();
        applyStimulus(1, 64'h29, 5'd1, 5'd2, 1, 1, 0, 1);
        evalCycle();
        advance();
        applyStimulus(0, '0, '0, '0, 0, 0, 0, 1);
        evalCycle();
        checkOutput("resume_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("resume_payload",   bus.out_payload,    64'h29);
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
